// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction memory read handshake plus the execute-stage
// interface. Fetch is the master; memory and execute together form the slave.
interface fetch_if;
  logic [31:0] o_addr;
  logic        o_rd_ready;
  logic [31:0] i_data;
  logic        i_rd_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_inst_valid;
  logic        i_finished;
  logic        i_pc_change;
  logic [31:0] i_new_pc;
  logic        i_invalid_inst;
  logic        o_halted;
  logic        o_misaligned;
  logic [31:0] o_retired;

  modport master (
    output o_addr, o_rd_ready, o_inst, o_pc, o_inst_valid,
           o_halted, o_misaligned, o_retired,
    input  i_data, i_rd_valid, i_finished, i_pc_change, i_new_pc, i_invalid_inst
  );

  modport slave (
    input  o_addr, o_rd_ready, o_inst, o_pc, o_inst_valid,
           o_halted, o_misaligned, o_retired,
    output i_data, i_rd_valid, i_finished, i_pc_change, i_new_pc, i_invalid_inst
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch/sequencing stage: owns the PC, fetches one word per
// instruction, hands it to execute and picks the next PC on completion.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic     i_clk,
  input  logic     i_rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_halted;
  logic        r_misaligned;
  logic [31:0] r_retired;

  state_t      w_state;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic        w_halted;
  logic        w_misaligned;
  logic [31:0] w_retired;
  logic [31:0] w_target;

  assign w_target = bus.i_pc_change ? bus.i_new_pc : (r_pc + 32'd4);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_inst       <= NOP_INST;
      r_halted     <= 1'b0;
      r_misaligned <= 1'b0;
      r_retired    <= 32'd0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_inst       <= w_inst;
      r_halted     <= w_halted;
      r_misaligned <= w_misaligned;
      r_retired    <= w_retired;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_inst       = r_inst;
    w_halted     = r_halted;
    w_misaligned = r_misaligned;
    w_retired    = r_retired;

    bus.o_rd_ready   = 1'b0;
    bus.o_addr       = 32'd0;
    bus.o_inst_valid = 1'b0;
    bus.o_inst       = NOP_INST;
    bus.o_pc         = r_pc;
    bus.o_halted     = r_halted;
    bus.o_misaligned = r_misaligned;
    bus.o_retired    = r_retired;

    case (r_state)
      S_FETCH: begin
        bus.o_rd_ready = 1'b1;
        bus.o_addr     = r_pc;
        if (bus.i_rd_valid) begin
          w_inst  = bus.i_data;
          w_state = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.o_inst_valid = 1'b1;
        bus.o_inst       = r_inst;
        if (bus.i_finished) begin
          if (bus.i_invalid_inst) begin
            // Illegal instruction: freeze the PC on it and do not retire it.
            w_state  = S_HALT;
            w_halted = 1'b1;
          end else begin
            w_retired = r_retired + 32'd1;
            w_pc      = w_target;
            if (w_target[1:0] != 2'b00) begin
              w_state      = S_HALT;
              w_halted     = 1'b1;
              w_misaligned = 1'b1;
            end else begin
              w_state = S_FETCH;
              w_inst  = NOP_INST;
            end
          end
        end
      end
      S_HALT: begin
        w_state = S_HALT;
      end
      default: begin
        w_state = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fetch_if bus ();

  fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All helpers start and end at a negedge with execute/memory inputs idle.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fetch_word(input logic [31:0] w);
    $display("fetch addr=%h inst=%h", bus.o_addr, w);
    bus.i_rd_valid = 1'b1;
    bus.i_data     = w;
    @(negedge clk);
    bus.i_rd_valid = 1'b0;
    bus.i_data     = 32'hDEAD_BEEF;
  endtask

  task automatic exec_finish(input logic chg, input logic [31:0] npc, input logic inv);
    $display("finish pc=%h chg=%0d new=%h inv=%0d", bus.o_pc, chg, npc, inv);
    bus.i_finished     = 1'b1;
    bus.i_pc_change    = chg;
    bus.i_new_pc       = npc;
    bus.i_invalid_inst = inv;
    @(negedge clk);
    bus.i_finished     = 1'b0;
    bus.i_pc_change    = 1'b0;
    bus.i_new_pc       = 32'd0;
    bus.i_invalid_inst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h want=%h", bus.o_addr, 32'h0); end
    checks++; if (bus.o_rd_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready got=%b want=1", bus.o_rd_ready); end
    checks++; if (bus.o_inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%b want=0", bus.o_inst_valid); end
    checks++; if (bus.o_inst !== NOP) begin errors++; $display("FAIL reset_inst got=%h want=%h", bus.o_inst, NOP); end
    checks++; if (bus.o_retired !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0d want=0", bus.o_retired); end
    checks++; if (bus.o_halted !== 1'b0 || bus.o_misaligned !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b%b want=00", bus.o_halted, bus.o_misaligned); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      w = 32'h0010_0093 + (i << 20);
      checks++; if (bus.o_addr !== 32'(4 * i) || bus.o_rd_ready !== 1'b1 || bus.o_inst_valid !== 1'b0) begin
        errors++; $display("FAIL zw_fetch%0d addr=%h rdy=%b vld=%b want addr=%h rdy=1 vld=0", i, bus.o_addr, bus.o_rd_ready, bus.o_inst_valid, 4 * i);
      end
      fetch_word(w);
      checks++; if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== w || bus.o_pc !== 32'(4 * i) || bus.o_addr !== 32'h0) begin
        errors++; $display("FAIL zw_exec%0d vld=%b inst=%h pc=%h addr=%h want vld=1 inst=%h pc=%h addr=0", i, bus.o_inst_valid, bus.o_inst, bus.o_pc, bus.o_addr, w, 4 * i);
      end
      exec_finish(1'b0, 32'd0, 1'b0);
    end
    checks++; if (bus.o_retired !== 32'd3) begin errors++; $display("FAIL zw_retired got=%0d want=3", bus.o_retired); end
    checks++; if (bus.o_addr !== 32'hC) begin errors++; $display("FAIL zw_next_addr got=%h want=0000000c", bus.o_addr); end
  endtask

  task automatic test_wait_states();
    // Advance from 0xC to 0x10.
    fetch_word(32'h0000_0013);
    exec_finish(1'b0, 32'd0, 1'b0);
    bus.i_data = 32'hBAD0_0BAD;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.o_addr !== 32'h10 || bus.o_rd_ready !== 1'b1 || bus.o_inst !== NOP) begin
        errors++; $display("FAIL ws_hold%0d addr=%h rdy=%b inst=%h want addr=00000010 rdy=1 inst=%h", k, bus.o_addr, bus.o_rd_ready, bus.o_inst, NOP);
      end
      @(negedge clk);
    end
    checks++; if (bus.o_addr !== 32'h10 || bus.o_rd_ready !== 1'b1) begin errors++; $display("FAIL ws_hold3 addr=%h rdy=%b want 00000010/1", bus.o_addr, bus.o_rd_ready); end
    fetch_word(32'h0050_0113);
    checks++; if (bus.o_inst !== 32'h0050_0113 || bus.o_pc !== 32'h10) begin errors++; $display("FAIL ws_latch inst=%h pc=%h want 00500113/00000010", bus.o_inst, bus.o_pc); end
    // A stretched EXEC must hold the instruction.
    repeat (2) @(negedge clk);
    checks++; if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== 32'h0050_0113 || bus.o_rd_ready !== 1'b0) begin
      errors++; $display("FAIL ws_stretch vld=%b inst=%h rdy=%b want 1/00500113/0", bus.o_inst_valid, bus.o_inst, bus.o_rd_ready);
    end
    exec_finish(1'b0, 32'd0, 1'b0);
    checks++; if (bus.o_retired !== 32'd5 || bus.o_addr !== 32'h14) begin errors++; $display("FAIL ws_done retired=%0d addr=%h want 5/00000014", bus.o_retired, bus.o_addr); end
  endtask

  task automatic test_redirect();
    fetch_word(32'h0000_0013);
    exec_finish(1'b1, 32'h20, 1'b0);
    checks++; if (bus.o_addr !== 32'h20) begin errors++; $display("FAIL rd_to20 got=%h want=00000020", bus.o_addr); end
    fetch_word(32'h0000_0063);
    bus.i_pc_change = 1'b1;
    bus.i_new_pc    = 32'h300;
    @(negedge clk);
    bus.i_pc_change = 1'b0;
    bus.i_new_pc    = 32'd0;
    checks++; if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== 32'h20) begin errors++; $display("FAIL rd_no_finish vld=%b pc=%h want 1/00000020", bus.o_inst_valid, bus.o_pc); end
    exec_finish(1'b1, 32'h100, 1'b0);
    checks++; if (bus.o_addr !== 32'h100 || bus.o_rd_ready !== 1'b1) begin errors++; $display("FAIL rd_to100 addr=%h rdy=%b want 00000100/1", bus.o_addr, bus.o_rd_ready); end
    checks++; if (bus.o_retired !== 32'd7) begin errors++; $display("FAIL rd_retired got=%0d want=7", bus.o_retired); end
  endtask

  task automatic test_misaligned();
    fetch_word(32'h0000_0067);
    exec_finish(1'b1, 32'h102, 1'b0);
    checks++; if (bus.o_halted !== 1'b1 || bus.o_misaligned !== 1'b1) begin errors++; $display("FAIL mis_flags got=%b%b want=11", bus.o_halted, bus.o_misaligned); end
    checks++; if (bus.o_retired !== 32'd8 || bus.o_pc !== 32'h102) begin errors++; $display("FAIL mis_state retired=%0d pc=%h want 8/00000102", bus.o_retired, bus.o_pc); end
    // Inputs must be ignored once halted.
    bus.i_rd_valid = 1'b1;
    bus.i_finished = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (bus.o_rd_ready !== 1'b0 || bus.o_inst_valid !== 1'b0 || bus.o_inst !== NOP || bus.o_retired !== 32'd8 || bus.o_halted !== 1'b1) begin
        errors++; $display("FAIL mis_hold%0d rdy=%b vld=%b inst=%h ret=%0d halt=%b want 0/0/%h/8/1", k, bus.o_rd_ready, bus.o_inst_valid, bus.o_inst, bus.o_retired, bus.o_halted, NOP);
      end
    end
    bus.i_rd_valid = 1'b0;
    bus.i_finished = 1'b0;
  endtask

  task automatic test_invalid();
    do_reset();
    fetch_word(32'h0000_006F);
    exec_finish(1'b1, 32'h40, 1'b0);
    fetch_word(32'hFFFF_FFFF);
    exec_finish(1'b1, 32'h80, 1'b1);
    checks++; if (bus.o_halted !== 1'b1 || bus.o_misaligned !== 1'b0) begin errors++; $display("FAIL inv_flags got=%b%b want=10", bus.o_halted, bus.o_misaligned); end
    checks++; if (bus.o_retired !== 32'd1 || bus.o_pc !== 32'h40 || bus.o_rd_ready !== 1'b0) begin
      errors++; $display("FAIL inv_state ret=%0d pc=%h rdy=%b want 1/00000040/0", bus.o_retired, bus.o_pc, bus.o_rd_ready);
    end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fetch_word(32'h0000_0013);
      exec_finish(1'b0, 32'd0, 1'b0);
    end
    fetch_word(32'h0000_006F);
    exec_finish(1'b1, 32'h80, 1'b0);
    fetch_word(32'h0000_0013);
    checks++; if (bus.o_pc !== 32'h80 || bus.o_retired !== 32'd5 || bus.o_inst_valid !== 1'b1) begin
      errors++; $display("FAIL rst_setup pc=%h ret=%0d vld=%b want 00000080/5/1", bus.o_pc, bus.o_retired, bus.o_inst_valid);
    end
    bus.i_finished = 1'b1;
    do_reset();
    bus.i_finished = 1'b0;
    checks++; if (bus.o_addr !== 32'h0 || bus.o_rd_ready !== 1'b1 || bus.o_retired !== 32'd0 || bus.o_halted !== 1'b0) begin
      errors++; $display("FAIL rst_mid addr=%h rdy=%b ret=%0d halt=%b want 0/1/0/0", bus.o_addr, bus.o_rd_ready, bus.o_retired, bus.o_halted);
    end
  endtask

  task automatic test_pc_wrap();
    fetch_word(32'h0000_006F);
    exec_finish(1'b1, 32'hFFFF_FFFC, 1'b0);
    checks++; if (bus.o_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got=%h want=fffffffc", bus.o_addr); end
    fetch_word(32'h0000_0013);
    exec_finish(1'b0, 32'd0, 1'b0);
    checks++; if (bus.o_addr !== 32'h0 || bus.o_halted !== 1'b0 || bus.o_retired !== 32'd2) begin
      errors++; $display("FAIL wrap_zero addr=%h halt=%b ret=%0d want 0/0/2", bus.o_addr, bus.o_halted, bus.o_retired);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.i_data         = 32'd0;
    bus.i_rd_valid     = 1'b0;
    bus.i_finished     = 1'b0;
    bus.i_pc_change    = 1'b0;
    bus.i_new_pc       = 32'd0;
    bus.i_invalid_inst = 1'b0;
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect();
    test_misaligned();
    test_invalid();
    test_reset_mid_exec();
    test_pc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
